// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and load-response producer handshakes plus the register-file write port.
interface wb_arbiter_if #(
    parameter int MXLEN  = 32,
    parameter int REG_AW = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [MXLEN-1:0]  alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [MXLEN-1:0]  lsu_data;
    logic [2:0]        lsu_funct3;
    logic [1:0]        lsu_addr_lo;

    logic              regwrite;
    logic [REG_AW-1:0] write1;
    logic [MXLEN-1:0]  write_data;
    logic              busy;

    // Producer / register-file side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_addr_lo,
        input  alu_ready, lsu_ready,
        input  regwrite, write1, write_data, busy
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_addr_lo,
        output alu_ready, lsu_ready,
        output regwrite, write1, write_data, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file write port.
// Latency: one cycle from handshake or skid drain to the registered write.
// Backpressure: both readies drop for exactly one cycle while the ALU skid entry drains.
module wb_arbiter #(
    parameter int MXLEN  = 32,
    parameter int REG_AW = 5
) (
    input  logic       CLK,
    input  logic       reset,
    wb_arbiter_if.slave bus
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [MXLEN-1:0]  data;
    } wb_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;
    wb_t    skid;
    wb_t    wr_sel;
    logic   wr_vld;
    logic   skid_load;

    // Load extension
    logic [4:0]       byte_lsb;
    logic [4:0]       half_lsb;
    logic [7:0]       byte_dat;
    logic [15:0]      half_dat;
    logic [MXLEN-1:0] load_ext;

    assign byte_lsb = {bus.lsu_addr_lo, 3'b000};
    assign half_lsb = {bus.lsu_addr_lo[1], 4'b0000};
    assign byte_dat = bus.lsu_data[byte_lsb +: 8];
    assign half_dat = bus.lsu_data[half_lsb +: 16];

    always_comb begin
        load_ext = bus.lsu_data;
        case (bus.lsu_funct3)
            3'b000:  load_ext = {{(MXLEN-8){byte_dat[7]}}, byte_dat};
            3'b001:  load_ext = {{(MXLEN-16){half_dat[15]}}, half_dat};
            3'b100:  load_ext = {{(MXLEN-8){1'b0}}, byte_dat};
            3'b101:  load_ext = {{(MXLEN-16){1'b0}}, half_dat};
            default: load_ext = bus.lsu_data;
        endcase
    end

    // Readies depend on state only so producers never see a valid->ready loop.
    assign bus.alu_ready = (state == SKID_EMPTY);
    assign bus.lsu_ready = (state == SKID_EMPTY);
    assign bus.busy      = (state == SKID_FULL);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_vld    = 1'b0;
        wr_sel    = '0;
        skid_load = 1'b0;
        case (state)
            SKID_FULL: begin
                wr_vld    = 1'b1;
                wr_sel    = skid;
                state_nxt = SKID_EMPTY;
            end
            default: begin
                if (bus.lsu_valid) begin
                    wr_vld      = 1'b1;
                    wr_sel.rd   = bus.lsu_rd;
                    wr_sel.data = load_ext;
                    // Concurrent ALU result is parked and written right after the load.
                    if (bus.alu_valid) begin
                        skid_load = 1'b1;
                        state_nxt = SKID_FULL;
                    end
                end else if (bus.alu_valid) begin
                    wr_vld      = 1'b1;
                    wr_sel.rd   = bus.alu_rd;
                    wr_sel.data = bus.alu_data;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            skid           <= '0;
            bus.regwrite   <= 1'b0;
            bus.write1     <= '0;
            bus.write_data <= '0;
        end else begin
            if (skid_load) begin
                skid.rd   <= bus.alu_rd;
                skid.data <= bus.alu_data;
            end
            if (wr_vld) begin
                // x0 still consumes the slot; only the enable is suppressed.
                bus.regwrite   <= (wr_sel.rd != '0);
                bus.write1     <= wr_sel.rd;
                bus.write_data <= wr_sel.data;
            end else begin
                bus.regwrite   <= 1'b0;
            end
        end
    end

endmodule
